// File: rtl/mem_slave_pipe.sv
// mem_slave_pipe: parametrised single-port memory slave with byte strobes,
//   programmable wait states and a pipelined, in-order read path.
// Latency: wack/werr one cycle after the accept edge; rvalid/rdata/rerr
//   RD_LAT cycles after the accept cycle (RD_LAT-1 edges after the accept edge).
// Backpressure: ready is Moore-driven (IDLE when WAIT_CYC=0, GRANT otherwise)
//   and forced low while rst is high; responses cannot be stalled.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   addr, wdata, wstrb    word address, write data, byte enables
//   wt_rd, valid, ready   1=write/0=read, request valid, slave ready
//   rdata, rvalid, rerr   read data, one-cycle read strobe, read error
//   wack, werr            one-cycle write acknowledge, write error
module mem_slave_pipe #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 2,
  parameter int WAIT_CYC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  input  logic                  wt_rd,
  input  logic                  valid,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  rerr,
  output logic                  wack,
  output logic                  werr
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so DEPTH = 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          WAIT_L  = 4'(WAIT_CYC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             xfer;
  logic             wr_xfer;
  logic             rd_xfer;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] rd_vld;
  logic [RD_LAT-1:0] rd_err;
  logic [WIDTH-1:0]  rd_dat [RD_LAT];

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign idx      = addr[IDX_W-1:0];

  // With no wait states the FSM never leaves IDLE, so IDLE itself means ready.
  // Gating with rst keeps ready low during the reset cycle itself.
  assign ready   = !rst && ((WAIT_CYC == 0) ? (state == S_IDLE) : (state == S_GRANT));
  assign xfer    = valid && ready;
  assign wr_xfer = xfer && wt_rd;
  assign rd_xfer = xfer && !wt_rd;

  // Wait-state FSM. cnt counts the ready-low cycles already spent after the
  // request was first seen; GRANT is entered as cnt reaches WAIT_CYC so ready
  // rises exactly WAIT_CYC cycles after valid was first sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else if (WAIT_CYC != 0) begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            state <= (WAIT_L == 4'd1) ? S_GRANT : S_STALL;
            cnt   <= 4'd1;
          end
        end
        S_STALL: begin
          if (!valid) begin
            // Master withdrew the request: abandon it silently.
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == WAIT_L) begin
              state <= S_GRANT;
            end
          end
        end
        S_GRANT: begin
          // Transfer (if valid is still up) happens on this edge.
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_xfer && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Write response: single stage, cancelled by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wack <= 1'b0;
      werr <= 1'b0;
    end else begin
      wack <= wr_xfer;
      werr <= wr_xfer && !in_range;
    end
  end

  // Read pipeline: stage 0 captures the memory word at the accept edge, the
  // remaining RD_LAT-1 stages only delay it. Idle stages carry zero so rdata
  // stays zero between responses and out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= '0;
      rd_err <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        rd_dat[k] <= '0;
      end
    end else begin
      rd_vld[0] <= rd_xfer;
      rd_err[0] <= rd_xfer && !in_range;
      rd_dat[0] <= (rd_xfer && in_range) ? mem[idx] : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        rd_vld[k] <= rd_vld[k-1];
        rd_err[k] <= rd_err[k-1];
        rd_dat[k] <= rd_dat[k-1];
      end
    end
  end

  assign rvalid = rd_vld[RD_LAT-1];
  assign rerr   = rd_err[RD_LAT-1];
  assign rdata  = rd_dat[RD_LAT-1];

endmodule

// File: tb/tb_mem_slave_pipe.sv
// tb_mem_slave_pipe: directed plus randomized bench for mem_slave_pipe.
// Three instances: A (DEPTH 200, RD_LAT 2, no waits) against a queue model,
// B (RD_LAT 4) for back-to-back reads, C (RD_LAT 3, WAIT_CYC 3) for wait states and reset.
module tb_mem_slave_pipe;

  logic        clk = 1'b0;
  logic        rst_ab, rst_c;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wt_rd;
  logic        valid_a, valid_b, valid_c;

  logic        ready_a, rvalid_a, rerr_a, wack_a, werr_a;
  logic        ready_b, rvalid_b, rerr_b, wack_b, werr_b;
  logic        ready_c, rvalid_c, rerr_c, wack_c, werr_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  always #5 clk = ~clk;

  mem_slave_pipe #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .RD_LAT(2), .WAIT_CYC(0)) dut_a (
    .clk(clk), .rst(rst_ab), .addr(addr), .wdata(wdata), .wstrb(wstrb), .wt_rd(wt_rd),
    .valid(valid_a), .ready(ready_a), .rdata(rdata_a), .rvalid(rvalid_a), .rerr(rerr_a),
    .wack(wack_a), .werr(werr_a));

  mem_slave_pipe #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LAT(4), .WAIT_CYC(0)) dut_b (
    .clk(clk), .rst(rst_ab), .addr(addr), .wdata(wdata), .wstrb(wstrb), .wt_rd(wt_rd),
    .valid(valid_b), .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b), .rerr(rerr_b),
    .wack(wack_b), .werr(werr_b));

  mem_slave_pipe #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LAT(3), .WAIT_CYC(3)) dut_c (
    .clk(clk), .rst(rst_c), .addr(addr), .wdata(wdata), .wstrb(wstrb), .wt_rd(wt_rd),
    .valid(valid_c), .ready(ready_c), .rdata(rdata_c), .rvalid(rvalid_c), .rerr(rerr_c),
    .wack(wack_c), .werr(werr_c));

  int vectors = 0;
  int miscompares = 0;

  // Reference model for instance A: word array plus a queue of pending reads
  // tagged with the edge number at which their response must be visible.
  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } rsp_t;

  logic [31:0] mm [200];
  rsp_t        rq [$];
  int          ne;
  logic [31:0] last_rd;
  logic        last_err;
  int          last_rd_edge, last_acc_edge;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock of instance A: drive, step the model, compare every response.
  task automatic cyc_a(input logic v, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    logic acc, exp_wack, exp_werr, exp_rv;
    rsp_t r;
    addr = a; wdata = d; wstrb = s; wt_rd = w; valid_a = v;
    chk1("a_ready", ready_a, 1'b1);
    acc = v && ready_a;
    @(posedge clk); #1;
    ne++;
    exp_wack = acc && w;
    exp_werr = acc && w && (a >= 8'd200);
    if (acc && w && a < 8'd200) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) mm[a][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (acc && !w) begin
      r.due = ne + 1;            // RD_LAT 2 => visible one edge after accept edge
      r.d   = (a < 8'd200) ? mm[a] : 32'd0;
      r.e   = (a >= 8'd200);
      rq.push_back(r);
      last_acc_edge = ne;
    end
    chk1("a_wack", wack_a, exp_wack);
    if (exp_wack) chk1("a_werr", werr_a, exp_werr);
    exp_rv = (rq.size() > 0) && (rq[0].due == ne);
    chk1("a_rvalid", rvalid_a, exp_rv);
    if (exp_rv) begin
      r = rq.pop_front();
      chk("a_rdata", rdata_a, r.d);
      chk1("a_rerr", rerr_a, r.e);
      last_rd = rdata_a;
      last_err = rerr_a;
      last_rd_edge = ne;
    end
  endtask

  // Instance C: hold a request until granted (bounded), transfer, drop valid.
  task automatic xfer_c(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n;
    addr = a; wdata = d; wstrb = 4'hF; wt_rd = w; valid_c = 1'b1;
    n = 0;
    while (!ready_c && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("c_grant", ready_c, 1'b1);
    chk("c_wait_cycles", 32'(n), 32'd3);
    @(posedge clk); #1;
    valid_c = 1'b0;
  endtask

  // Instance C: count edges until rvalid (bounded) and check the response.
  task automatic read_c(input logic [7:0] a, input logic [31:0] exp_d);
    int n;
    xfer_c(1'b0, a, 32'd0);
    n = 0;
    while (!rvalid_c && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("c_rd_latency", 32'(n), 32'd2);
    chk1("c_rvalid", rvalid_c, 1'b1);
    chk("c_rdata", rdata_c, exp_d);
    chk1("c_rerr", rerr_c, 1'b0);
  endtask

  logic        ob_v [10];
  logic [31:0] ob_d [10];

  initial begin
    int          seen;
    logic        ev, rw;
    logic [7:0]  ra;

    rst_ab = 1'b1; rst_c = 1'b1;
    addr = '0; wdata = '0; wstrb = '0; wt_rd = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    ne = 0;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready_a", ready_a, 1'b0);
    chk1("rst_ready_c", ready_c, 1'b0);
    chk1("rst_rvalid_a", rvalid_a, 1'b0);
    chk1("rst_wack_a", wack_a, 1'b0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    rst_ab = 1'b0; rst_c = 1'b0;
    @(posedge clk); #1;
    chk1("post_rst_ready_a", ready_a, 1'b1);
    chk1("post_rst_ready_b", ready_b, 1'b1);
    chk1("post_rst_ready_c", ready_c, 1'b0);
    chk1("post_rst_rvalid_a", rvalid_a, 1'b0);
    chk1("post_rst_rerr_a", rerr_a, 1'b0);
    chk1("post_rst_wack_a", wack_a, 1'b0);
    chk1("post_rst_werr_a", werr_a, 1'b0);
    chk("post_rst_rdata_a", rdata_a, 32'd0);

    // ---- A: fill every word so later reads have a defined model value
    for (int i = 0; i < 200; i++) cyc_a(1'b1, 1'b1, 8'(i), $urandom, 4'hF);

    // ---- A: write/read-back with latency
    cyc_a(1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    cyc_a(1'b1, 1'b0, 8'h10, 32'd0, 4'h0);
    cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    chk("plan_rd_deadbeef", last_rd, 32'hDEADBEEF);
    chk("plan_rd_latency_edges", 32'(last_rd_edge - last_acc_edge), 32'd1);

    // ---- A: byte strobes, read issued on the very next edge
    cyc_a(1'b1, 1'b1, 8'h10, 32'h11223344, 4'h5);
    cyc_a(1'b1, 1'b0, 8'h10, 32'd0, 4'h0);
    cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    chk("plan_strobe_merge", last_rd, 32'hDE22BE44);

    // ---- A: out of range
    cyc_a(1'b1, 1'b1, 8'hC8, 32'h12345678, 4'hF);
    chk1("plan_oor_werr", werr_a, 1'b1);
    cyc_a(1'b1, 1'b0, 8'hC8, 32'd0, 4'h0);
    cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    chk1("plan_oor_rerr", last_err, 1'b1);
    chk("plan_oor_rdata", last_rd, 32'd0);
    cyc_a(1'b1, 1'b0, 8'h00, 32'd0, 4'h0);
    cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    chk1("plan_inrange_rerr", last_err, 1'b0);

    // ---- A: random traffic, mostly in range
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 199)) : 8'($urandom_range(0, 255));
      rw = 1'($urandom_range(0, 1));
      cyc_a(1'($urandom_range(0, 3) != 0), rw, ra, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 4; i++) cyc_a(1'b0, 1'b0, 8'h00, 32'd0, 4'h0);
    chk("a_drain_pending", 32'(rq.size()), 32'd0);
    valid_a = 1'b0;

    // ---- B: RD_LAT 4, four back-to-back reads
    for (int i = 1; i <= 4; i++) begin
      addr = 8'(i); wdata = 32'hB0B00000 | 32'(i); wstrb = 4'hF; wt_rd = 1'b1; valid_b = 1'b1;
      @(posedge clk); #1;
      chk1("b_wack", wack_b, 1'b1);
    end
    valid_b = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      if (j < 4) begin
        valid_b = 1'b1; wt_rd = 1'b0; addr = 8'(j + 1);
      end else begin
        valid_b = 1'b0;
      end
      @(posedge clk); #1;
      ob_v[j] = rvalid_b;
      ob_d[j] = rdata_b;
    end
    for (int j = 0; j < 10; j++) begin
      ev = (j >= 3 && j <= 6);
      chk1("b_rvalid_train", ob_v[j], ev);
      if (ev) chk("b_rdata_order", ob_d[j], 32'hB0B00000 | 32'(j - 2));
    end

    // ---- C: wait states, valid held from cycle 0
    addr = 8'd5; wdata = 32'hCAFE0005; wstrb = 4'hF; wt_rd = 1'b1; valid_c = 1'b1;
    chk1("c_ready_cycle0", ready_c, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk1("c_ready_cycle_k", ready_c, (k == 3));
    end
    @(posedge clk); #1;
    valid_c = 1'b0;
    chk1("c_wack", wack_c, 1'b1);
    chk1("c_werr", werr_c, 1'b0);
    chk1("c_ready_after", ready_c, 1'b0);
    read_c(8'd5, 32'hCAFE0005);

    // ---- C: request withdrawn during STALL produces nothing
    addr = 8'd6; wt_rd = 1'b1; valid_c = 1'b1;
    @(posedge clk); #1;
    valid_c = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      seen += int'(wack_c) + int'(ready_c) + int'(rvalid_c);
    end
    chk("c_withdrawn_activity", 32'(seen), 32'd0);

    // ---- C: reset one cycle after a read accept drops the response
    xfer_c(1'b0, 8'd5, 32'd0);
    rst_c = 1'b1;
    chk1("c_ready_in_rst", ready_c, 1'b0);
    seen = int'(rvalid_c);
    @(posedge clk); #1;
    rst_c = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen += int'(rvalid_c);
      @(posedge clk); #1;
    end
    chk("c_rst_dropped_rvalid", 32'(seen), 32'd0);
    read_c(8'd5, 32'hCAFE0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_slave_pipe.md
Name: mem_slave_pipe

Overview:
- Parametrised single-port memory slave; the DUT behind the memory bus interface (addr/wdata/rdata/wt_rd/valid/ready).
- Generalises the basic memory target:
  - configurable width, depth and read latency
  - byte write strobes
  - programmable wait-state insertion on ready
  - pipelined back-to-back reads
  - separate read/write response strobes with out-of-range error reporting

Parameters:
- WIDTH, 32, data width in bits; multiple of 8.
- ADDR_WIDTH, 8, address width in bits (word address).
- DEPTH, 256, number of words; 1 to 2**ADDR_WIDTH.
- RD_LAT, 2, cycles from read accept edge to rvalid; 1 to 4.
- WAIT_CYC, 0, ready-low cycles inserted before each accept; 0 to 15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_WIDTH  word address.
- wdata  in  WIDTH  write data.
- wstrb  in  WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i].
- wt_rd  in  1  1 = write, 0 = read.
- valid  in  1  request valid.
- ready  out  1  slave can accept; transfer when valid && ready at a rising edge.
- rdata  out  WIDTH  read data; meaningful only when rvalid = 1.
- rvalid  out  1  one-cycle read response strobe.
- rerr  out  1  read error; qualified by rvalid.
- wack  out  1  one-cycle write acknowledge.
- werr  out  1  write error; qualified by wack.

Behaviour:
Reset:
- ready, rvalid, rerr, wack, werr = 0; rdata = 0.
- Read pipeline flushed; wait counter = 0; FSM -> IDLE.
- Memory contents are not cleared by rst.

Handshake and wait states:
- Master holds addr, wdata, wstrb and wt_rd stable while valid && !ready.
- WAIT_CYC = 0:
  - FSM stays in IDLE with ready = 1 every cycle after reset.
  - Back-to-back transfers accepted every cycle.
- WAIT_CYC > 0, FSM IDLE -> STALL -> GRANT -> IDLE:
  - IDLE: ready = 0. If valid is seen at edge T, go to STALL with cnt = 1.
  - STALL: ready = 0; cnt increments each cycle. When cnt = WAIT_CYC, go to GRANT.
  - GRANT: ready = 1. Transfer occurs at this edge, then return to IDLE.
  - Net effect: ready first goes high WAIT_CYC cycles after valid is first sampled.
- valid dropping in STALL or GRANT (protocol violation): return to IDLE, no transfer, no response.

Writes (accept at edge T):
- addr < DEPTH:
  - Each byte with wstrb[i] = 1 is updated at edge T; other bytes are unchanged.
  - wack = 1 in cycle T+1, werr = 0.
- addr >= DEPTH: memory unchanged; wack = 1 and werr = 1 in cycle T+1.
- wstrb = 0 with addr in range: legal no-op; wack = 1, werr = 0.

Reads (accept at edge T):
- rvalid = 1 with rdata for exactly one cycle, RD_LAT cycles after edge T.
- addr >= DEPTH: rdata = 0 and rerr = 1 with rvalid.
- Pipeline depth is RD_LAT; one read may be accepted per cycle with no bubbles.
- Responses return in request order.

Ordering and hazards:
- A read accepted at the edge after a write to the same address returns the new data (write-then-read).
- Write and read pipelines are independent; wack and rvalid may be high in the same cycle.

Reset mid-operation:
- In-flight reads are dropped (no rvalid).
- A pending wack is cancelled.
- Writes accepted before the reset edge remain in memory.

Test Plan:
- Reset, WAIT_CYC = 0: after rst deasserts, ready = 1 and all response outputs = 0.
- Write and read-back, WIDTH = 32:
  - Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF -> wack = 1 one cycle later, werr = 0.
  - Read 0x10 -> rvalid = 1 exactly RD_LAT = 2 cycles after accept, rdata = 0xDEADBEEF.
- Byte strobes:
  - Write 0x10 with 0x11223344, wstrb 0x5 over 0xDEADBEEF -> later read returns 0xDE22BE44.
- Out of range, DEPTH = 200:
  - Write 0xC8 -> wack = 1, werr = 1.
  - Read 0xC8 -> rvalid = 1, rerr = 1, rdata = 0.
  - Read 0x00 -> rerr = 0.
- Wait states and pipelining:
  - WAIT_CYC = 3, valid held from cycle 0 -> ready = 1 only in cycle 3; transfer at cycle 3.
  - WAIT_CYC = 0, RD_LAT = 4, reads of addrs 1, 2, 3, 4 on consecutive cycles -> four consecutive rvalid pulses, in order, with correct data.
- Reset mid-read: rst asserted one cycle after a read accept with RD_LAT = 3 -> no rvalid ever appears for that read.
